// File: rtl/spio_spinnaker_link_tx_queue.sv
// Packet queue ahead of the SpiNNaker link sender: fixes header parity, blanks
// short-packet payloads, buffers packets and drops a head the link refuses too long.
module spio_spinnaker_link_tx_queue #(
    parameter int DEPTH_BITS = 2,
    parameter int TO_BITS    = 16
) (
    input  logic               CLK_IN,
    input  logic               RESET_IN,
    input  logic [71:0]        IN_DATA_IN,
    input  logic               IN_VLD_IN,
    output logic               IN_RDY_OUT,
    output logic [71:0]        PKT_DATA_OUT,
    output logic               PKT_VLD_OUT,
    input  logic               PKT_RDY_IN,
    input  logic [TO_BITS-1:0] TIMEOUT_IN,
    output logic [15:0]        DROP_CNT_OUT,
    input  logic               DROP_CNT_CLR_IN
);
    localparam int PKT_BITS = 72;
    localparam int DEPTH    = 1 << DEPTH_BITS;

    logic [PKT_BITS-1:0]   mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS:0]   occ;
    logic [TO_BITS-1:0]    wait_cnt;
    logic [15:0]           drop_cnt;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  accept;
    logic                  stall;
    logic                  drop;
    logic                  pop;

    // Short packets carry no payload; bit 0 makes the whole word's popcount odd.
    function automatic logic [PKT_BITS-1:0] fix_pkt(input logic [PKT_BITS-1:0] d);
        logic [PKT_BITS-1:0] w;
        w = d;
        if (!d[1]) w[71:40] = '0;
        w[0] = ~(^w[PKT_BITS-1:1]);
        return w;
    endfunction

    assign full   = occ[DEPTH_BITS];
    assign empty  = (occ == '0);
    assign push   = IN_VLD_IN && !full;
    assign accept = !empty && PKT_RDY_IN;
    assign stall  = !empty && !PKT_RDY_IN;
    // wait_cnt counts earlier stall cycles, so this is the T-th consecutive stall.
    assign drop   = stall && (TIMEOUT_IN != '0) &&
                    (({1'b0, wait_cnt} + (TO_BITS+1)'(1)) >= {1'b0, TIMEOUT_IN});
    assign pop    = accept || drop;

    assign IN_RDY_OUT   = !full;
    assign PKT_VLD_OUT  = !empty;
    assign PKT_DATA_OUT = empty ? '0 : mem[rd_ptr];
    assign DROP_CNT_OUT = drop_cnt;

    always_ff @(posedge CLK_IN) begin
        if (push) mem[wr_ptr] <= fix_pkt(IN_DATA_IN);
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (DEPTH_BITS+1)'(1);
                2'b01:   occ <= occ - (DEPTH_BITS+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            wait_cnt <= '0;
        end else if (!stall || drop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + TO_BITS'(1);
        end
    end

    // A clear beats a coincident drop, which then goes uncounted.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN || DROP_CNT_CLR_IN) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_spio_spinnaker_link_tx_queue.sv
// Directed bench for the link tx queue: a queue-based reference model checked every
// cycle, plus literal expectations for the parity, fill, timeout and reset cases.
module tb_spio_spinnaker_link_tx_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [71:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy = 1'b0;
    logic [15:0] timeout = '0;
    logic [15:0] drop_cnt;
    logic        clr = 1'b0;

    int tests = 0;
    int fails = 0;

    spio_spinnaker_link_tx_queue #(.DEPTH_BITS(2), .TO_BITS(16)) dut (
        .CLK_IN(clk), .RESET_IN(rst),
        .IN_DATA_IN(in_data), .IN_VLD_IN(in_vld), .IN_RDY_OUT(in_rdy),
        .PKT_DATA_OUT(pkt_data), .PKT_VLD_OUT(pkt_vld), .PKT_RDY_IN(pkt_rdy),
        .TIMEOUT_IN(timeout), .DROP_CNT_OUT(drop_cnt), .DROP_CNT_CLR_IN(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the stored word must be, by counting ones directly.
    function automatic logic [71:0] exp_word(input logic [71:0] d);
        logic [71:0] w;
        w = d;
        if (!d[1]) w[71:40] = '0;
        w[0] = 1'b0;
        if (($countones(w) % 2) == 0) w[0] = 1'b1;
        return w;
    endfunction

    logic [71:0] mq[$];
    int          stall_run = 0;
    int          mdrops = 0;
    bit          armed = 0;

    always @(posedge clk) begin
        bit m_vld, m_acc, m_stall, m_drop, m_push;
        if (rst) begin
            mq.delete();
            stall_run = 0;
            mdrops = 0;
            armed = 1;
        end else begin
            m_vld   = (mq.size() != 0);
            m_acc   = m_vld && pkt_rdy;
            m_stall = m_vld && !pkt_rdy;
            m_drop  = m_stall && (timeout != 0) && (stall_run + 1 >= int'(timeout));
            m_push  = in_vld && (mq.size() < 4);
            if (m_acc || m_drop) void'(mq.pop_front());
            if (m_push) mq.push_back(exp_word(in_data));
            if (m_stall && !m_drop) stall_run = (stall_run < 65535) ? stall_run + 1 : 65535;
            else stall_run = 0;
            if (clr) mdrops = 0;
            else if (m_drop && mdrops < 65535) mdrops++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_rdy", {71'd0, in_rdy}, {71'd0, mq.size() < 4});
            check("pkt_vld", {71'd0, pkt_vld}, {71'd0, mq.size() != 0});
            check("pkt_data", pkt_data, (mq.size() != 0) ? mq[0] : 72'd0);
            check("drop_cnt", {56'd0, drop_cnt}, 72'(mdrops));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] keys [5];
    int          n;
    int          cnt;

    initial begin
        repeat (2) step();
        rst = 1'b0;
        check("reset_vld", {71'd0, pkt_vld}, 72'd0);
        check("reset_rdy", {71'd0, in_rdy}, 72'd1);
        check("reset_data", pkt_data, 72'd0);
        check("reset_drops", {56'd0, drop_cnt}, 72'd0);

        // Short packet: payload blanked, 13 ones already odd.
        in_data = {32'hFFFFFFFF, 32'h12345678, 8'h00};
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        check("short_vld", {71'd0, pkt_vld}, 72'd1);
        check("short_data", pkt_data, {32'h0, 32'h12345678, 8'h00});
        pkt_rdy = 1'b1;
        step();
        pkt_rdy = 1'b0;

        // Long packets: parity set regardless of the incoming bit 0.
        in_data = {32'h3, 32'h12345678, 8'h02};
        in_vld = 1'b1;
        step();
        in_data = {32'h3, 32'h12345678, 8'h03};
        step();
        in_vld = 1'b0;
        check("long_hdr_a", pkt_data, {32'h3, 32'h12345678, 8'h03});
        pkt_rdy = 1'b1;
        step();
        check("long_hdr_b", pkt_data, {32'h3, 32'h12345678, 8'h03});
        step();
        pkt_rdy = 1'b0;
        check("long_empty", {71'd0, pkt_vld}, 72'd0);

        // Fill with five packets; the fifth waits.
        for (int i = 0; i < 5; i++) begin
            in_data = {32'(i + 1), 32'hA0 + 32'(i), 8'h02};
            in_vld = 1'b1;
            step();
            if (i == 3) check("full_rdy", {71'd0, in_rdy}, 72'd0);
        end
        check("fill_head", {40'd0, pkt_data[39:8]}, 72'hA0);
        pkt_rdy = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (pkt_vld && n < 5) begin
                keys[n] = pkt_data[39:8];
                n++;
            end
            step();
            if (c == 1) in_vld = 1'b0;
        end
        pkt_rdy = 1'b0;
        check("drain_count", 72'(n), 72'd5);
        for (int k = 0; k < 5; k++) check("drain_order", {40'd0, keys[k]}, 72'hA0 + 72'(k));

        // Timeout 8: head visible for exactly 8 cycles, then dropped.
        timeout = 16'd8;
        in_data = {32'h5, 32'hCAFE0001, 8'h02};
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (pkt_vld) cnt++;
            step();
        end
        check("to_cycles", 72'(cnt), 72'd8);
        check("to_drops", {56'd0, drop_cnt}, 72'd1);

        // Ready in the 8th cycle wins over the drop.
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (7) step();
        pkt_rdy = 1'b1;
        step();
        pkt_rdy = 1'b0;
        check("acc8_vld", {71'd0, pkt_vld}, 72'd0);
        check("acc8_drops", {56'd0, drop_cnt}, 72'd0);

        // Lowering the timeout mid-stall drops on the next stall cycle.
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (3) step();
        timeout = 16'd2;
        step();
        check("live_vld", {71'd0, pkt_vld}, 72'd0);
        check("live_drops", {56'd0, drop_cnt}, 72'd1);

        // Saturate the drop counter with a drop every cycle.
        timeout = 16'd1;
        in_data = {32'h7, 32'h0BADF00D, 8'h00};
        in_vld = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (mdrops == 65535) break;
            step();
        end
        check("sat_reach", {56'd0, drop_cnt}, 72'hFFFF);
        repeat (4) step();
        check("sat_hold", {56'd0, drop_cnt}, 72'hFFFF);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_wins", {56'd0, drop_cnt}, 72'd0);
        in_vld = 1'b0;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Reset with three packets queued.
        timeout = 16'd0;
        in_vld = 1'b1;
        repeat (3) step();
        in_vld = 1'b0;
        check("pre_rst_vld", {71'd0, pkt_vld}, 72'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_vld", {71'd0, pkt_vld}, 72'd0);
        check("rst_rdy", {71'd0, in_rdy}, 72'd1);
        check("rst_drops", {56'd0, drop_cnt}, 72'd0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spio_spinnaker_link_tx_queue.md
# spio_spinnaker_link_tx_queue

Packet queue placed directly upstream of the SpiNNaker link sender. It accepts packets from the on-chip switch or router over a valid/ready interface and recomputes each header's odd-parity bit. It zeroes the payload field of short packets and buffers packets in a small FIFO. The head packet is offered to the sender; a head the sender fails to accept within a programmable timeout is discarded and counted, so a dead link cannot stall the upstream fabric.

## Interface
- `DEPTH_BITS`, default 2: FIFO holds 2^DEPTH_BITS packets.
- `TO_BITS`, default 16: width of the timeout value and of the wait counter.
- `CLK_IN` input 1: the single clock.
- `RESET_IN` input 1: reset, synchronous and active-high.
- `IN_DATA_IN` input `PKT_BITS` (72): incoming packet.
  - Bits [7:0]: header. Bit 1 = long, bit 0 = parity.
  - Bits [39:8]: key.
  - Bits [71:40]: payload.
- `IN_VLD_IN` input 1: incoming packet valid.
- `IN_RDY_OUT` output 1: queue can accept a packet.
- `PKT_DATA_OUT` output 72: head packet, connects to the sender's `PKT_DATA_IN`.
- `PKT_VLD_OUT` output 1: head valid, connects to the sender's `PKT_VLD_IN`.
- `PKT_RDY_IN` input 1: from the sender's `PKT_RDY_OUT`.
- `TIMEOUT_IN` input `TO_BITS`: stall limit in cycles; 0 disables dropping.
- `DROP_CNT_OUT` output 16: saturating count of dropped packets.
- `DROP_CNT_CLR_IN` input 1: clears the drop counter.

## Operation
- **Push.** A push occurs when `IN_VLD_IN && IN_RDY_OUT`.
  - `IN_RDY_OUT` = !full, decoded from the registered occupancy count.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- **Write processing.** The stored word is derived from the input as follows.
  - If `IN_DATA_IN[1]` = 0, bits [71:40] are forced to 0.
  - Bit 0 is replaced so that the population count over the packet is odd. The count covers bits [39:0] for short packets and [71:0] for long packets.
  - All other bits pass through unchanged.
- **Head offer.** `PKT_VLD_OUT` = !empty and `PKT_DATA_OUT` = the head entry.
  - Data is held stable while `PKT_VLD_OUT` is high and the head has not been popped.
- **Accept.** An accept occurs when `PKT_VLD_OUT && PKT_RDY_IN`; the head pops on that edge. The sender raises `PKT_RDY_OUT` only when idle, and it captures the packet whenever it sees VLD while idle.
- **Stall.** A stall cycle is one with `PKT_VLD_OUT && !PKT_RDY_IN`.
  - The wait counter (`TO_BITS` wide) increments on each stall cycle, saturating.
  - It clears on an accept, on a drop, or when `PKT_VLD_OUT` = 0.
- **Drop.** A drop occurs on a stall cycle where `TIMEOUT_IN` != 0 and wait_cnt >= `TIMEOUT_IN` - 1.
  - The head pops without being transferred, and the drop counter increments, saturating at 0xFFFF.
  - `TIMEOUT_IN` is compared live, so lowering it mid-stall triggers a drop on the next stall cycle.
- **Drop counter clear.** `DROP_CNT_CLR_IN` sets the counter to 0 and takes priority over a simultaneous drop; that drop is not counted.
- **Pointers and occupancy.** Read and write pointers are `DEPTH_BITS` wide and wrap naturally. Occupancy is `DEPTH_BITS`+1 bits wide.
  - A simultaneous push and pop, when not full, leaves occupancy unchanged.

## Timing
- **Reset.** `RESET_IN` is sampled on a rising `CLK_IN` edge. After the edge:
  - occupancy = 0, pointers = 0, wait_cnt = 0;
  - `PKT_VLD_OUT` = 0, `PKT_DATA_OUT` = 0, `IN_RDY_OUT` = 1, `DROP_CNT_OUT` = 0.
- **Reset mid-operation.** All queued packets are discarded and are not counted as drops.
- **Latency.** A packet pushed at edge N into an empty queue appears with `PKT_VLD_OUT` = 1 in the cycle after edge N.
- **Throughput.**
  - Input side: one push per cycle while not full.
  - Output side: one pop per cycle. The sender itself limits actual transfers to one per packet transmission.
- **Drop timing.** With `TIMEOUT_IN` = T, the head is dropped at the edge closing the T-th consecutive stall cycle.
  - The next entry, if any, is presented in the following cycle.
- **Accept wins over drop.** If `PKT_RDY_IN` is high in the cycle a drop would occur, that cycle is an accept, not a stall, so no drop occurs.

## Test plan
- **Short packet parity.** Push header 0x00, key 0x12345678, payload 0xFFFFFFFF. Required output:
  - payload 0;
  - bit 0 = 0 (13 ones, already odd);
  - VLD high one cycle after the push.
- **Long packet parity.** Push header 0x02, key 0x12345678, payload 0x00000003 (16 ones). Required output header 0x03.
  - Then push header 0x03 with the same key and payload. Required output header 0x03 again, since the input parity bit is ignored.
- **Fill and backpressure.** With `DEPTH_BITS` = 2, `PKT_RDY_IN` = 0 and `TIMEOUT_IN` = 0, push 5 packets.
  - Required: `IN_RDY_OUT` falls after the 4th push; the 5th is held off.
  - With `PKT_RDY_IN` then raised, packets emerge in FIFO order. In any cycle where the queue is full and a pop occurs, there is no push.
- **Timeout drop.** With `TIMEOUT_IN` = 8, one packet queued and `PKT_RDY_IN` = 0:
  - Required: `PKT_VLD_OUT` is high for exactly 8 cycles, then falls.
  - `DROP_CNT_OUT` = 1.
  - With `PKT_RDY_IN` raised in the 8th cycle instead, the packet is accepted and the drop count stays 0.
- **Drop count saturate and clear.** Force the drop counter to 0xFFFF, then cause a further drop. Required: it stays 0xFFFF.
  - Assert `DROP_CNT_CLR_IN` in the same cycle as a drop. Required: counter = 0.
- **Reset with 3 queued packets.** Required: after the reset edge, `PKT_VLD_OUT` = 0, `IN_RDY_OUT` = 1 and `DROP_CNT_OUT` unchanged at 0.
